ram_wr_ctrl: RTL and testbench
==============================

# ram_wr_ctrl

Write-side controller for the two-clock RAM (write port on clk_1, read port on clk_2). It accepts a burst request and a valid/ready data stream, and drives the RAM write port with registered outputs. Addresses increment from a base and wrap modulo DEPTH. It publishes a Gray-coded write pointer so the clk_2 read side can tell how many entries have landed.

## Interface
- WIDTH, 8, data word width
- DEPTH, 8, RAM entries; must equal 2**NUMBER
- NUMBER, 3, address width
- clk_1  in  1  write-domain clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  burst request; sampled only in IDLE
- base_addr  in  NUMBER  first write address; sampled with start
- len  in  NUMBER+1  burst length in words; legal range 1..DEPTH
- abort  in  1  terminate burst; effective only in WRITE
- s_valid  in  1  stream word valid
- s_data  in  WIDTH  stream word
- s_ready  out  1  stream ready; combinational, state==WRITE && !abort
- cs_n  out  1  RAM chip select, active low
- we_n  out  1  RAM write enable, active low
- addr_w  out  NUMBER  RAM write address
- data_in  out  WIDTH  RAM write data
- busy  out  1  high in WRITE and DONE
- done  out  1  one-cycle pulse; burst completed normally
- err  out  1  one-cycle pulse; start was given with an illegal len
- wr_ptr_gray  out  NUMBER+1  Gray-coded count of completed writes

## Operation
- Reset values: state IDLE, cs_n=1, we_n=1, addr_w=0, data_in=0, done=0, err=0, wr_ptr_gray=0, internal counters 0. Reset applied mid-burst aborts the burst immediately, with no further RAM writes.
- FSM states are IDLE, WRITE and DONE.
- IDLE:
  - start with 1<=len<=DEPTH: latch base_addr into cur_addr and len into remaining, then go to WRITE.
  - start with len==0 or len>DEPTH: err=1 for the next cycle and stay in IDLE.
- WRITE: a beat is accepted on a clk_1 edge where s_valid && s_ready. On each beat:
  - register we_n=0, addr_w=cur_addr, data_in=s_data;
  - cur_addr <= cur_addr+1, wrapping mod DEPTH (e.g., 7 -> 0);
  - decrement remaining.
  - A cycle with no beat registers we_n=1 and holds addr_w/data_in.
- Last beat (remaining==1): go to DONE.
- DONE: lasts one cycle with done=1; we_n is low for the final word in this cycle. Then go to IDLE.
- abort in WRITE: s_ready is forced low, so no beat is accepted that cycle. Next state is IDLE, done is not pulsed, and writes already issued stand.
- start outside IDLE is ignored.
- cs_n is decoded from the registered state: low in WRITE and DONE, high in IDLE. The read side shares the RAM's cs_n, so reads are valid only while busy.
- Write pointer: a (NUMBER+1)-bit binary count increments once per completed write and wraps mod 2**(NUMBER+1). It persists across bursts and is cleared only by reset. wr_ptr_gray is the registered value bin ^ (bin>>1).

## Timing
- start at edge t gives busy=1 and s_ready=1 during cycle t+1.
- Beat accepted at edge k: we_n, addr_w and data_in are valid during cycle k+1, and the RAM captures the word at edge k+2.
- wr_ptr_gray updates at edge k+2, after the write has landed, so the pointer never leads the data.
- Minimum burst (len=1, s_valid held high):
  - start at t; beat at t+1; DONE during t+2 with we_n=0; IDLE at t+3.
  - done is high for exactly cycle t+2.
- Back-to-back bursts: start is accepted in the first IDLE cycle after DONE. There is one idle cycle (cs_n=1) between bursts.
- Full-rate streaming sustains one word per clk_1 cycle.
- Only one bit of wr_ptr_gray changes per edge; it is the sole signal intended to cross into clk_2, via a 2-flop synchronizer on the read side.

## Structure
- Shared package ram_pkg holds:
  - WIDTH/DEPTH/NUMBER defaults;
  - the FSM state encoding constants (IDLE, WRITE, DONE);
  - a bin2gray function, which the read-side controller also uses.
- One sub-module, ram_wr_ptr: binary counter plus registered Gray output, with inc and reset_n inputs. It is reusable for the read pointer.

## Test plan
- Reset mid-burst: start base=2 len=6, reset after 3 beats -> outputs at reset values, wr_ptr_gray=0, no further we_n pulses, RAM[2..4] written only.
- Wrap: base=6 len=4, data A1..A4 -> writes 6,7,0,1 with A1..A4; done pulse once; wr_ptr_gray 0->1->3->2->6.
- Backpressure: len=3, s_valid low on alternate cycles -> exactly 3 we_n pulses, addr 0,1,2, data order preserved, done after the third.
- Abort: len=5, abort with s_valid high after 2 beats -> 2 writes only, abort-cycle word not accepted, no done, IDLE next cycle.
- Illegal length: start with len=0, then len=9 -> err pulses twice, busy stays 0, cs_n stays 1.
- Min burst plus back-to-back: len=1 then immediately len=8 at base 0 -> cycle timing as in Timing; pointer count 9 gives wr_ptr_gray=4'b1101.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared definitions for the two-clock RAM controllers.
// Holds the default geometry, the write FSM state encoding and the
// binary-to-Gray helper that both pointer sides use.
package ram_pkg;

  localparam int RAM_WIDTH  = 8;
  localparam int RAM_NUMBER = 3;
  localparam int RAM_DEPTH  = 1 << RAM_NUMBER;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wr_state_e;

  // Operates on a 32-bit container; callers truncate to their pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/ram_wr_ctrl_if.sv
// Stream input and RAM write-port bundle for the write controller.
// master: the controller (consumes the stream, drives the RAM port).
// slave : the environment (produces the stream, observes the RAM port).
//   s_valid/s_data/s_ready : valid/ready word stream
//   cs_n/we_n              : RAM chip select / write enable, active low
//   addr_w/data_in         : RAM write address / write data
interface ram_wr_ctrl_if import ram_pkg::*; #(
  parameter int WIDTH  = RAM_WIDTH,
  parameter int NUMBER = RAM_NUMBER
) ();

  logic              s_valid;
  logic [WIDTH-1:0]  s_data;
  logic              s_ready;
  logic              cs_n;
  logic              we_n;
  logic [NUMBER-1:0] addr_w;
  logic [WIDTH-1:0]  data_in;

  modport master (
    input  s_valid, s_data,
    output s_ready, cs_n, we_n, addr_w, data_in
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, cs_n, we_n, addr_w, data_in
  );

endinterface

// File: rtl/ram_wr_ptr.sv
// Binary entry counter with a registered Gray-coded copy, usable for either
// side of the RAM.
//   clk, reset_n : clock, asynchronous active-low reset
//   inc          : advance the count by one this edge
//   gray         : registered Gray code of the count (one bit changes per step)
module ram_wr_ptr import ram_pkg::*; #(
  parameter int PW = RAM_NUMBER + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          inc,
  output logic [PW-1:0] gray
);

  logic [PW-1:0] bin;
  logic [PW-1:0] bin_nxt;

  assign bin_nxt = bin + PW'(inc);

  // Gray is derived from the next count so both registers move on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_nxt;
      gray <= PW'(bin2gray(32'(bin_nxt)));
    end
  end

endmodule

// File: rtl/ram_wr_ctrl.sv
// Write-side controller for the two-clock RAM. Takes a burst request
// (base_addr, len) and a valid/ready stream, and writes the words to
// consecutive RAM addresses (wrapping) with registered port outputs.
//   clk_1, reset_n     : write clock, asynchronous active-low reset
//   start/base_addr/len: burst request, sampled in IDLE
//   abort              : end the burst early (WRITE only)
//   bus                : stream in + RAM write port (master modport)
//   busy/done/err      : status; done and err are one-cycle pulses
//   wr_ptr_gray        : Gray-coded count of writes that have landed
//
// state | meaning
// IDLE  | waiting for start; RAM deselected
// WRITE | accepting stream beats, one RAM write per beat
// DONE  | final word on the RAM port, done pulsed
module ram_wr_ctrl import ram_pkg::*; #(
  parameter int WIDTH  = RAM_WIDTH,
  parameter int DEPTH  = RAM_DEPTH,
  parameter int NUMBER = RAM_NUMBER
) (
  input  logic              clk_1,
  input  logic              reset_n,
  input  logic              start,
  input  logic [NUMBER-1:0] base_addr,
  input  logic [NUMBER:0]   len,
  input  logic              abort,
  ram_wr_ctrl_if.master     bus,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [NUMBER:0]   wr_ptr_gray
);

  wr_state_e         state;
  logic [NUMBER-1:0] cur_addr;
  logic [NUMBER:0]   remaining;
  logic              we_n_q;
  logic [NUMBER-1:0] addr_q;
  logic [WIDTH-1:0]  data_q;
  logic              len_ok;
  logic              beat;

  assign len_ok      = (len != '0) && (len <= (NUMBER+1)'(DEPTH));
  assign bus.s_ready = (state == WRITE) && !abort;
  assign beat        = bus.s_valid && bus.s_ready;

  assign busy        = (state == WRITE) || (state == DONE);
  assign bus.cs_n    = !busy;
  assign bus.we_n    = we_n_q;
  assign bus.addr_w  = addr_q;
  assign bus.data_in = data_q;

  always_ff @(posedge clk_1 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      we_n_q    <= 1'b1;
      addr_q    <= '0;
      data_q    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      we_n_q <= 1'b1;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              cur_addr  <= base_addr;
              remaining <= len;
              state     <= WRITE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (abort) begin
            state <= IDLE;
          end else if (beat) begin
            we_n_q    <= 1'b0;
            addr_q    <= cur_addr;
            data_q    <= bus.s_data;
            // DEPTH is a power of two, so natural overflow is the wrap.
            cur_addr  <= cur_addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == (NUMBER+1)'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A write counts once the RAM has sampled it: the edge that ends the
  // cycle in which we_n was low.
  ram_wr_ptr #(.PW(NUMBER + 1)) u_wr_ptr (
    .clk     (clk_1),
    .reset_n (reset_n),
    .inc     (!we_n_q),
    .gray    (wr_ptr_gray)
  );

endmodule

// File: tb/tb_ram_wr_ctrl.sv
module tb_ram_wr_ctrl;
  import ram_pkg::*;

  logic       clk_1 = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] base_addr = '0;
  logic [3:0] len = '0;
  logic       busy, done, err;
  logic [3:0] wr_ptr_gray;

  ram_wr_ctrl_if #(.WIDTH(8), .NUMBER(3)) bus ();

  ram_wr_ctrl #(.WIDTH(8), .DEPTH(8), .NUMBER(3)) dut (
    .clk_1       (clk_1),
    .reset_n     (reset_n),
    .start       (start),
    .base_addr   (base_addr),
    .len         (len),
    .abort       (abort),
    .bus         (bus.master),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .wr_ptr_gray (wr_ptr_gray)
  );

  always #5 clk_1 = ~clk_1;

  int          n_asserts = 0;
  int          n_fail = 0;
  logic [10:0] sb[$];
  logic [3:0]  gq[$];
  logic [7:0]  mem[8];
  int          we_cnt, done_cnt, err_cnt, spurious;
  logic [3:0]  prev_gray = '0;
  logic [2:0]  exp_addr;
  logic [10:0] mon_e;
  logic [3:0]  exp_gray[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_1);
    #1;
  endtask

  task automatic clear_counts();
    we_cnt = 0; done_cnt = 0; err_cnt = 0; spurious = 0;
    gq.delete();
  endtask

  task automatic start_burst(input logic [2:0] b, input logic [3:0] l);
    base_addr = b; len = l; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic beat(input logic [7:0] d);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    chk("s_ready_beat", 32'(bus.s_ready), 32'd1);
    sb.push_back({exp_addr, d});
    exp_addr = exp_addr + 3'd1;
    tick();
  endtask

  // Simple RAM model on the write port.
  always @(posedge clk_1)
    if (bus.cs_n === 1'b0 && bus.we_n === 1'b0) mem[bus.addr_w] <= bus.data_in;

  // Scoreboard and pulse monitor, sampled mid-cycle.
  always @(negedge clk_1) begin
    if (reset_n) begin
      if (bus.we_n === 1'b0) begin
        we_cnt++;
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("wr_addr", 32'(bus.addr_w), 32'(mon_e[10:8]));
          chk("wr_data", 32'(bus.data_in), 32'(mon_e[7:0]));
        end else begin
          spurious++;
        end
      end
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) err_cnt++;
    end
    if (wr_ptr_gray !== prev_gray) begin
      if (reset_n) chk("gray_one_bit", 32'($countones(wr_ptr_gray ^ prev_gray)), 32'd1);
      gq.push_back(wr_ptr_gray);
      prev_gray = wr_ptr_gray;
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    clear_counts();
    repeat (2) @(posedge clk_1);
    #1 reset_n = 1'b1;
    tick();

    // Reset state
    chk("rst_cs_n", 32'(bus.cs_n), 32'd1);
    chk("rst_we_n", 32'(bus.we_n), 32'd1);
    chk("rst_addr_w", 32'(bus.addr_w), 32'd0);
    chk("rst_data_in", 32'(bus.data_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_gray", 32'(wr_ptr_gray), 32'd0);
    chk("rst_s_ready", 32'(bus.s_ready), 32'd0);

    // Reset mid-burst: base 2, len 6, three writes land, then reset.
    clear_counts();
    exp_addr = 3'd2;
    start_burst(3'd2, 4'd6);
    beat(8'h11); beat(8'h12); beat(8'h13);
    bus.s_valid = 1'b0;
    tick();
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h99;
    reset_n = 1'b0;
    #1;
    chk("midrst_cs_n", 32'(bus.cs_n), 32'd1);
    chk("midrst_we_n", 32'(bus.we_n), 32'd1);
    chk("midrst_addr_w", 32'(bus.addr_w), 32'd0);
    chk("midrst_data_in", 32'(bus.data_in), 32'd0);
    chk("midrst_gray", 32'(wr_ptr_gray), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    bus.s_valid = 1'b0;
    reset_n = 1'b1;
    repeat (3) tick();
    chk("midrst_we_count", 32'(we_cnt), 32'd3);
    chk("midrst_ram2", 32'(mem[2]), 32'h11);
    chk("midrst_ram3", 32'(mem[3]), 32'h12);
    chk("midrst_ram4", 32'(mem[4]), 32'h13);
    chk("midrst_ram5", 32'(mem[5]), 32'h00);
    chk("midrst_gray_after", 32'(wr_ptr_gray), 32'd0);
    chk("midrst_sb_left", 32'(sb.size()), 32'd0);
    sb.delete();

    // Wrap: base 6, len 4.
    clear_counts();
    exp_addr = 3'd6;
    start_burst(3'd6, 4'd4);
    beat(8'hA1); beat(8'hA2); beat(8'hA3); beat(8'hA4);
    bus.s_valid = 1'b0;
    chk("wrap_done", 32'(done), 32'd1);
    chk("wrap_done_we_n", 32'(bus.we_n), 32'd0);
    chk("wrap_done_addr", 32'(bus.addr_w), 32'd1);
    tick();
    chk("wrap_idle_busy", 32'(busy), 32'd0);
    chk("wrap_idle_cs_n", 32'(bus.cs_n), 32'd1);
    repeat (2) tick();
    chk("wrap_ram6", 32'(mem[6]), 32'hA1);
    chk("wrap_ram7", 32'(mem[7]), 32'hA2);
    chk("wrap_ram0", 32'(mem[0]), 32'hA3);
    chk("wrap_ram1", 32'(mem[1]), 32'hA4);
    chk("wrap_done_count", 32'(done_cnt), 32'd1);
    exp_gray[0] = 4'd1; exp_gray[1] = 4'd3; exp_gray[2] = 4'd2; exp_gray[3] = 4'd6;
    chk("wrap_gray_steps", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("wrap_gray_seq", 32'(gq[i]), 32'(exp_gray[i]));

    // Backpressure: len 3, valid on alternate cycles.
    clear_counts();
    exp_addr = 3'd0;
    start_burst(3'd0, 4'd3);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) begin
        beat(8'hB0 + 8'(i));
      end else begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'hFF;
        chk("bp_ready_idle_beat", 32'(bus.s_ready), 32'd1);
        tick();
      end
    end
    bus.s_valid = 1'b0;
    chk("bp_done", 32'(done), 32'd1);
    repeat (3) tick();
    chk("bp_we_count", 32'(we_cnt), 32'd3);
    chk("bp_done_count", 32'(done_cnt), 32'd1);
    chk("bp_ram0", 32'(mem[0]), 32'hB0);
    chk("bp_ram1", 32'(mem[1]), 32'hB2);
    chk("bp_ram2", 32'(mem[2]), 32'hB4);
    chk("bp_gray", 32'(wr_ptr_gray), 32'b0100);

    // Abort after two beats, with s_valid high in the abort cycle.
    clear_counts();
    exp_addr = 3'd3;
    start_burst(3'd3, 4'd5);
    beat(8'hC1); beat(8'hC2);
    abort = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hEE;
    #1;
    chk("abort_s_ready", 32'(bus.s_ready), 32'd0);
    tick();
    abort = 1'b0;
    bus.s_valid = 1'b0;
    chk("abort_next_busy", 32'(busy), 32'd0);
    chk("abort_next_cs_n", 32'(bus.cs_n), 32'd1);
    chk("abort_next_we_n", 32'(bus.we_n), 32'd1);
    repeat (3) tick();
    chk("abort_we_count", 32'(we_cnt), 32'd2);
    chk("abort_done_count", 32'(done_cnt), 32'd0);
    chk("abort_ram3", 32'(mem[3]), 32'hC1);
    chk("abort_ram4", 32'(mem[4]), 32'hC2);
    chk("abort_ram5", 32'(mem[5]), 32'h00);
    chk("abort_gray", 32'(wr_ptr_gray), 32'b1101);

    // Illegal lengths.
    clear_counts();
    base_addr = 3'd0; len = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_len0", 32'(err), 32'd1);
    chk("err_len0_busy", 32'(busy), 32'd0);
    chk("err_len0_cs_n", 32'(bus.cs_n), 32'd1);
    tick();
    chk("err_len0_clear", 32'(err), 32'd0);
    len = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_len9", 32'(err), 32'd1);
    chk("err_len9_busy", 32'(busy), 32'd0);
    chk("err_len9_cs_n", 32'(bus.cs_n), 32'd1);
    repeat (2) tick();
    chk("err_count", 32'(err_cnt), 32'd2);
    chk("err_no_writes", 32'(we_cnt), 32'd0);

    // Minimum burst then back-to-back full burst, from a fresh pointer.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    clear_counts();
    exp_addr = 3'd5;
    base_addr = 3'd5; len = 4'd1; start = 1'b1;
    bus.s_valid = 1'b1; bus.s_data = 8'h51;
    tick();
    start = 1'b0;
    chk("min_busy_t1", 32'(busy), 32'd1);
    chk("min_ready_t1", 32'(bus.s_ready), 32'd1);
    chk("min_cs_n_t1", 32'(bus.cs_n), 32'd0);
    sb.push_back({exp_addr, 8'h51});
    tick();
    chk("min_done_t2", 32'(done), 32'd1);
    chk("min_we_n_t2", 32'(bus.we_n), 32'd0);
    chk("min_addr_t2", 32'(bus.addr_w), 32'd5);
    chk("min_data_t2", 32'(bus.data_in), 32'h51);
    tick();
    chk("min_busy_t3", 32'(busy), 32'd0);
    chk("min_cs_n_t3", 32'(bus.cs_n), 32'd1);
    chk("min_done_t3", 32'(done), 32'd0);
    exp_addr = 3'd0;
    start_burst(3'd0, 4'd8);
    for (int i = 0; i < 8; i++) beat(8'h80 + 8'(i));
    bus.s_valid = 1'b0;
    chk("b2b_done", 32'(done), 32'd1);
    repeat (3) tick();
    chk("b2b_done_count", 32'(done_cnt), 32'd2);
    chk("b2b_we_count", 32'(we_cnt), 32'd9);
    chk("b2b_gray", 32'(wr_ptr_gray), 32'b1101);
    chk("b2b_ram0", 32'(mem[0]), 32'h80);
    chk("b2b_ram5", 32'(mem[5]), 32'h85);
    chk("b2b_ram7", 32'(mem[7]), 32'h87);
    chk("b2b_sb_left", 32'(sb.size()), 32'd0);
    chk("spurious_writes", 32'(spurious), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
